// File: rtl/phaser_ctrl_pkg.sv
// phaser_ctrl_pkg: shared tap widths and FSM state encoding for the phaser tap controller
package phaser_ctrl_pkg;
  localparam int FINE_W = 6;
  localparam int COARSE_W = 3;
  localparam int CNT_W = 9;
  localparam int SETTLE_W = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_C_STEP,
    S_C_WAIT,
    S_F_STEP,
    S_F_WAIT,
`ifdef PHASER_TAP_READBACK_EN
    S_RDBK,
`endif
    S_FIN
  } phaser_state_t;
endpackage

// File: rtl/phaser_settle_timer.sv
// phaser_settle_timer: reloadable countdown that expires after SETTLE_CYCLES counting cycles
module phaser_settle_timer
  import phaser_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);
  logic [SETTLE_W-1:0] r_cnt;
  // load on the step cycle so the count covers exactly SETTLE_CYCLES wait cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
    else if (i_count && r_cnt != '0) r_cnt <= r_cnt - SETTLE_W'(1);
  assign o_expire = r_cnt == '0;
endmodule

// File: rtl/phaser_out_tap_ctrl.sv
// phaser_out_tap_ctrl: steps phaser coarse then fine taps to a target; PHASER_TAP_READBACK_EN adds a counter readback state
module phaser_out_tap_ctrl
  import phaser_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned FINE_MAX = 63,
  parameter int unsigned COARSE_MAX = 7
) (
  input  logic                SYSCLK,
  input  logic                RST,
  input  logic                REQVALID,
  output logic                REQREADY,
  input  logic [FINE_W-1:0]   REQFINE,
  input  logic [COARSE_W-1:0] REQCOARSE,
  output logic                DONE,
  output logic                BUSY,
  output logic                ERR,
  output logic [FINE_W-1:0]   CURFINE,
  output logic [COARSE_W-1:0] CURCOARSE,
  output logic                FINEENABLE,
  output logic                FINEINC,
  output logic                COARSEENABLE,
  output logic                COARSEINC,
`ifdef PHASER_TAP_READBACK_EN
  output logic                COUNTERREADEN,
  input  logic [CNT_W-1:0]    COUNTERREADVAL,
  output logic [CNT_W-1:0]    RDBKVAL,
`endif
  input  logic                FINEOVERFLOW,
  input  logic                COARSEOVERFLOW
);
  phaser_state_t r_state, w_next, w_after, w_end, w_rdbk_next;
  logic [FINE_W-1:0] r_cur_f, r_tgt_f;
  logic [COARSE_W-1:0] r_cur_c, r_tgt_c;
  logic r_err;
  logic w_ne_f, w_ne_c, w_ovf, w_wait, w_load, w_expire, w_illegal;
  assign w_ne_c = r_cur_c != r_tgt_c;
  assign w_ne_f = r_cur_f != r_tgt_f;
  assign w_ovf = FINEOVERFLOW | COARSEOVERFLOW;
  assign w_wait = r_state == S_C_WAIT || r_state == S_F_WAIT;
  assign w_illegal = 32'(REQFINE) > FINE_MAX || 32'(REQCOARSE) > COARSE_MAX;
  assign COARSEENABLE = r_state == S_C_STEP && w_ne_c;
  assign FINEENABLE = r_state == S_F_STEP && w_ne_f;
  assign COARSEINC = COARSEENABLE && r_cur_c < r_tgt_c;
  assign FINEINC = FINEENABLE && r_cur_f < r_tgt_f;
  assign w_load = COARSEENABLE || FINEENABLE;
  assign REQREADY = r_state == S_IDLE;
  assign BUSY = r_state != S_IDLE;
  assign DONE = r_state == S_FIN;
  assign ERR = r_err;
  assign CURFINE = r_cur_f;
  assign CURCOARSE = r_cur_c;
  assign w_after = w_ne_c ? S_C_STEP : w_ne_f ? S_F_STEP : w_end;

  phaser_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(SYSCLK),
    .rst(RST),
    .i_load(w_load),
    .i_count(w_wait),
    .o_expire(w_expire)
  );

`ifdef PHASER_TAP_READBACK_EN
  logic [1:0] r_rd_cnt;
  assign w_end = S_RDBK;
  assign w_rdbk_next = r_rd_cnt == 2'd2 ? S_FIN : S_RDBK;
  assign COUNTERREADEN = r_state == S_RDBK && r_rd_cnt == 2'd0;
  // time the readback: strobe on entry, capture the counter two cycles later
  always_ff @(posedge SYSCLK or posedge RST)
    if (RST) begin
      r_rd_cnt <= '0;
      RDBKVAL <= '0;
    end else begin
      r_rd_cnt <= r_state == S_RDBK ? r_rd_cnt + 2'd1 : 2'd0;
      if (r_state == S_RDBK && r_rd_cnt == 2'd2) RDBKVAL <= COUNTERREADVAL;
    end
`else
  assign w_end = S_FIN;
  assign w_rdbk_next = S_FIN;
`endif

  // next state: coarse phase, then fine phase, waits abort to FIN on overflow
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = !REQVALID ? S_IDLE : w_illegal ? S_FIN : S_C_STEP;
      S_C_STEP: w_next = w_ne_c ? S_C_WAIT : w_ne_f ? S_F_STEP : w_end;
      S_F_STEP: w_next = w_ne_f ? S_F_WAIT : w_end;
      S_C_WAIT, S_F_WAIT: w_next = w_ovf ? S_FIN : w_expire ? w_after : r_state;
`ifdef PHASER_TAP_READBACK_EN
      S_RDBK:   w_next = w_rdbk_next;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  // state, latched target, current taps and sticky error
  always_ff @(posedge SYSCLK or posedge RST)
    if (RST) begin
      r_state <= S_IDLE;
      r_tgt_f <= '0;
      r_tgt_c <= '0;
      r_cur_f <= '0;
      r_cur_c <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (REQVALID && r_state == S_IDLE) begin
        r_tgt_f <= REQFINE;
        r_tgt_c <= REQCOARSE;
        r_err <= w_illegal;
      end else if (w_wait && w_ovf) r_err <= 1'b1;
      if (COARSEENABLE) r_cur_c <= COARSEINC ? r_cur_c + COARSE_W'(1) : r_cur_c - COARSE_W'(1);
      if (FINEENABLE) r_cur_f <= FINEINC ? r_cur_f + FINE_W'(1) : r_cur_f - FINE_W'(1);
    end
endmodule

// File: tb/tb_phaser_out_tap_ctrl.sv
// tb_phaser_out_tap_ctrl: directed scoreboard bench for the phaser tap controller
module tb_phaser_out_tap_ctrl;
`ifdef PHASER_TAP_READBACK_EN
  localparam int RB = 3;
`else
  localparam int RB = 0;
`endif
  logic SYSCLK = 0, RST = 1, REQVALID = 0;
  logic [5:0] REQFINE = 0;
  logic [2:0] REQCOARSE = 0;
  logic FINEOVERFLOW = 0, COARSEOVERFLOW = 0;
  logic REQREADY, DONE, BUSY, ERR, FINEENABLE, FINEINC, COARSEENABLE, COARSEINC;
  logic [5:0] CURFINE;
  logic [2:0] CURCOARSE;
`ifdef PHASER_TAP_READBACK_EN
  logic COUNTERREADEN;
  logic [8:0] COUNTERREADVAL = 9'h0A5;
  logic [8:0] RDBKVAL;
`endif
  int tests = 0, fails = 0, cyc = 0, last_evt = 0, rd_pulses = 0;
  typedef struct {int kind; int inc; int gap; int f; int c; int err; int rd;} ev_t;
  ev_t sb[$];

  phaser_out_tap_ctrl #(.SETTLE_CYCLES(8), .FINE_MAX(50), .COARSE_MAX(7)) dut (
    .SYSCLK(SYSCLK), .RST(RST), .REQVALID(REQVALID), .REQREADY(REQREADY),
    .REQFINE(REQFINE), .REQCOARSE(REQCOARSE), .DONE(DONE), .BUSY(BUSY), .ERR(ERR),
    .CURFINE(CURFINE), .CURCOARSE(CURCOARSE), .FINEENABLE(FINEENABLE), .FINEINC(FINEINC),
    .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
`ifdef PHASER_TAP_READBACK_EN
    .COUNTERREADEN(COUNTERREADEN), .COUNTERREADVAL(COUNTERREADVAL), .RDBKVAL(RDBKVAL),
`endif
    .FINEOVERFLOW(FINEOVERFLOW), .COARSEOVERFLOW(COARSEOVERFLOW)
  );

  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc++;

  function automatic void chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  function automatic void push_steps(int kind, int inc, int first_gap, int n);
    for (int i = 0; i < n; i++) sb.push_back('{kind, inc, i == 0 ? first_gap : 9, 0, 0, 0, 0});
  endfunction

  function automatic void push_done(int gap, int f, int c, int err, int rd);
    sb.push_back('{2, 0, gap, f, c, err, rd});
  endfunction

  task automatic req(input logic [5:0] f, input logic [2:0] c);
    @(negedge SYSCLK);
    chk("reqready_before_req", int'(REQREADY), 1);
    REQVALID = 1; REQFINE = f; REQCOARSE = c;
    @(posedge SYSCLK);
    #1;
    last_evt = cyc;
    REQVALID = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge SYSCLK);
      n++;
    end
    if (sb.size() != 0) begin
      chk("scoreboard_drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge SYSCLK);
  endtask

  task automatic wait_fine_strobes(input int n);
    int k = 0, t = 0;
    while (k < n && t < 300) begin
      @(negedge SYSCLK);
      t++;
      if (FINEENABLE) k++;
    end
    chk("fine_strobe_wait", k, n);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_reqready"}, int'(REQREADY), 1);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_done"}, int'(DONE), 0);
    chk({tag, "_err"}, int'(ERR), 0);
    chk({tag, "_curfine"}, int'(CURFINE), 0);
    chk({tag, "_curcoarse"}, int'(CURCOARSE), 0);
    chk({tag, "_strobes_inc"}, int'({FINEENABLE, FINEINC, COARSEENABLE, COARSEINC}), 0);
`ifdef PHASER_TAP_READBACK_EN
    chk({tag, "_rden"}, int'(COUNTERREADEN), 0);
`endif
  endtask

  // monitor: every strobe or DONE pops one expected event and is checked against it
  always @(negedge SYSCLK) begin
    ev_t e;
    int kind;
    if (!RST) begin
`ifdef PHASER_TAP_READBACK_EN
      if (COUNTERREADEN) rd_pulses++;
`endif
      if (COARSEENABLE || FINEENABLE || DONE) begin
        kind = DONE ? 2 : FINEENABLE ? 1 : 0;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
          e = sb.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_gap", cyc - last_evt, e.gap);
          if (kind < 2) chk("step_inc", kind == 1 ? int'(FINEINC) : int'(COARSEINC), e.inc);
          else begin
            chk("done_curfine", int'(CURFINE), e.f);
            chk("done_curcoarse", int'(CURCOARSE), e.c);
            chk("done_err", int'(ERR), e.err);
`ifdef PHASER_TAP_READBACK_EN
            chk("rden_pulses", rd_pulses, e.rd);
            if (e.rd != 0) chk("rdbkval", int'(RDBKVAL), 'h0A5);
            rd_pulses = 0;
`endif
          end
        end
        last_evt = cyc;
      end
    end
  end

  initial begin
    repeat (2) @(negedge SYSCLK);
    chk_reset_values("in_reset");
    RST = 0;
    @(negedge SYSCLK);
    chk_reset_values("after_reset");
    // (0,0) -> (5,2): coarse up then fine up, busy request ignored
    push_steps(0, 1, 0, 2);
    push_steps(1, 1, 9, 5);
    push_done(9 + RB, 5, 2, 0, 1);
    req(6'd5, 3'd2);
    repeat (4) @(negedge SYSCLK);
    chk("busy_mid_move", int'(BUSY), 1);
    chk("reqready_mid_move", int'(REQREADY), 0);
    REQVALID = 1; REQFINE = 0; REQCOARSE = 0;
    @(negedge SYSCLK);
    REQVALID = 0;
    wait_done();
    chk("idle_after_move", int'(BUSY), 0);
    // (5,2) -> (1,0): everything down
    push_steps(0, 0, 0, 2);
    push_steps(1, 0, 9, 4);
    push_done(9 + RB, 1, 0, 0, 1);
    req(6'd1, 3'd0);
    wait_done();
    // equal request: no strobes, DONE two cycles after acceptance
    push_done(1 + RB, 1, 0, 0, 1);
    req(6'd1, 3'd0);
    wait_done();
    // fine target above FINE_MAX: error, immediate DONE, no steps
    push_done(0, 1, 0, 1, 0);
    req(6'd51, 3'd0);
    wait_done();
    chk("err_sticky_idle", int'(ERR), 1);
    // legal request clears the error; (1,0) -> (0,0)
    push_steps(1, 0, 1, 1);
    push_done(9 + RB, 0, 0, 0, 1);
    req(6'd0, 3'd0);
    wait_done();
    // overflow during third fine wait aborts with CURFINE=3
    push_steps(1, 1, 1, 3);
    push_done(2, 3, 0, 1, 0);
    req(6'd6, 3'd0);
    wait_fine_strobes(3);
    @(posedge SYSCLK);
    @(negedge SYSCLK);
    FINEOVERFLOW = 1;
    @(negedge SYSCLK);
    FINEOVERFLOW = 0;
    wait_done();
    chk("err_after_overflow", int'(ERR), 1);
    push_done(1 + RB, 3, 0, 0, 1);
    req(6'd3, 3'd0);
    wait_done();
    chk("err_cleared", int'(ERR), 0);
    // asynchronous reset in the middle of a fine wait
    push_steps(1, 1, 1, 1);
    req(6'd6, 3'd0);
    wait_fine_strobes(1);
    repeat (3) @(negedge SYSCLK);
    chk("busy_before_reset", int'(BUSY), 1);
    #2 RST = 1;
    #1 chk_reset_values("async_reset");
    @(negedge SYSCLK);
    RST = 0;
    chk("sb_empty_at_reset", sb.size(), 0);
    sb.delete();
    repeat (20) @(negedge SYSCLK);
    chk_reset_values("post_reset_quiet");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/phaser_out_tap_ctrl.md
PHASER_OUT_TAP_CTRL -- requirements
Module: phaser_out_tap_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  SETTLE_CYCLES, 8, idle cycles after each tap step (1..255).
  FINE_MAX, 63, highest legal fine tap.
  COARSE_MAX, 7, highest legal coarse tap.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning). The block has one clock, SYSCLK, and an asynchronous active-high reset, RST.
  SYSCLK  in  1  sole clock.
  RST  in  1  asynchronous, active-high reset.
  REQVALID  in  1  move request valid.
  REQREADY  out  1  high only in IDLE.
  REQFINE  in  6  target fine tap.
  REQCOARSE  in  3  target coarse tap.
  DONE  out  1  one-cycle completion pulse.
  BUSY  out  1  high outside IDLE.
  ERR  out  1  sticky error flag.
  CURFINE  out  6  current fine tap.
  CURCOARSE  out  3  current coarse tap.
  FINEENABLE, FINEINC  out  1 each  fine step strobe and direction to the phaser.
  COARSEENABLE, COARSEINC  out  1 each  coarse step strobe and direction to the phaser.
  FINEOVERFLOW, COARSEOVERFLOW  in  1 each  overflow flags from the phaser.

Function
REQ-003 A request SHALL be accepted on the SYSCLK edge where REQVALID and REQREADY are both high; REQFINE/REQCOARSE SHALL be latched then.
REQ-004 A request with REQFINE>FINE_MAX or REQCOARSE>COARSE_MAX SHALL:
  - set ERR;
  - pulse DONE the next cycle;
  - issue no steps.
REQ-005 The FSM states SHALL be IDLE, C_STEP, C_WAIT, F_STEP, F_WAIT, FIN (plus RDBK with the macro of REQ-014).
REQ-006 Ordering: all coarse steps first, then all fine steps.
  - Direction INC=1 when target > current, else INC=0.
REQ-007 C_STEP/F_STEP SHALL:
  - assert the matching ENABLE for exactly one cycle, with INC valid in that same cycle;
  - update CUR* by ±1 on that edge.
REQ-008 C_WAIT/F_WAIT SHALL hold all enables low for exactly SETTLE_CYCLES cycles. Back-to-back strobes are therefore spaced SETTLE_CYCLES+1 cycles apart.
REQ-009 When CUR equals the target, the FSM SHALL move to the next phase; FIN SHALL pulse DONE for one cycle, then return to IDLE.
REQ-010 A request equal to the current position SHALL pulse DONE 2 cycles after acceptance, with no strobes.
REQ-011 Overflow: FINEOVERFLOW or COARSEOVERFLOW sampled high in any WAIT state SHALL:
  - set ERR;
  - abort to FIN;
  - leave CUR* unchanged from its last value.
REQ-012 REQVALID while BUSY SHALL be ignored. ERR SHALL clear only on the next accepted request that is legal.

Reset
REQ-013 Reset SHALL act asynchronously, including mid-move; no strobe is completed afterwards. Reset values:
  - state=IDLE, REQREADY=1, BUSY=0, DONE=0, ERR=0;
  - CURFINE=0, CURCOARSE=0;
  - all ENABLE and INC outputs 0.

Configuration
REQ-014 Macro PHASER_TAP_READBACK_EN, when defined, SHALL:
  - add ports COUNTERREADEN (out, 1), COUNTERREADVAL (in, 9) and RDBKVAL (out, 9, reset 0);
  - insert state RDBK before FIN, which pulses COUNTERREADEN for 1 cycle and captures COUNTERREADVAL into RDBKVAL 2 cycles later, then enters FIN.
REQ-015 Without PHASER_TAP_READBACK_EN, those ports and RDBK SHALL be absent and DONE timing SHALL be as in REQ-009.

Structure
REQ-016 A shared package phaser_ctrl_pkg SHALL hold:
  - the FSM state enum;
  - the tap width constants (6 fine, 3 coarse, 9 counter).
REQ-017 One sub-module, phaser_settle_timer (load/count/expire), SHALL implement the WAIT countdown; no others.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - Reset, then request fine=5, coarse=2, SETTLE_CYCLES=8 -> 2 COARSEENABLE and 5 FINEENABLE pulses with INC=1, strobes 9 cycles apart, DONE once, CURFINE=5, CURCOARSE=2.
  - From (5,2), request (1,0) -> 2 coarse then 4 fine strobes with INC=0; final CUR=(1,0).
  - Request equal to current -> zero strobes, DONE 2 cycles after acceptance.
  - Assert FINEOVERFLOW during the 3rd fine wait -> ERR=1, DONE pulse, CURFINE=3, no further strobes; a next legal request clears ERR.
  - RST asserted mid-F_WAIT -> outputs take reset values immediately (asynchronous), no DONE; REQVALID during BUSY is ignored.
  - With PHASER_TAP_READBACK_EN, drive COUNTERREADVAL=9'h0A5 -> RDBKVAL=9'h0A5 before DONE, with COUNTERREADEN high for exactly 1 cycle.
